// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: steers a decoded instruction pair onto the branch and memory pipes,
// splitting structurally conflicting or intra-pair RAW-dependent pairs over two cycles.
module dual_issue_scheduler #(
    parameter int PAYLOAD = 96,
    parameter int RS      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         dec_valid,
    input  logic [1:0]         dec_class0,
    input  logic [1:0]         dec_class1,
    input  logic [PAYLOAD-1:0] dec_payload0,
    input  logic [PAYLOAD-1:0] dec_payload1,
    input  logic [RS-1:0]      dec_rd0,
    input  logic               dec_rf_we0,
    input  logic [RS-1:0]      dec_rs1_1,
    input  logic [RS-1:0]      dec_rs2_1,
    input  logic               hold,
    input  logic               flush,
    output logic               dec_stall,
    output logic               br_valid,
    output logic               mem_valid,
    output logic [PAYLOAD-1:0] br_payload,
    output logic [PAYLOAD-1:0] mem_payload,
    output logic               br_older,
    output logic [31:0]        split_count
);
    typedef enum logic {PAIR, SPLIT} state_t;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;

    state_t             state_q, state_d;
    logic               held_valid_q, held_valid_d;
    logic [1:0]         held_class_q, held_class_d;
    logic [PAYLOAD-1:0] held_payload_q, held_payload_d;
    logic               br_valid_q, br_valid_d, mem_valid_q, mem_valid_d;
    logic [PAYLOAD-1:0] br_payload_q, br_payload_d, mem_payload_q, mem_payload_d;
    logic               br_older_q, br_older_d;
    logic [31:0]        split_count_q, split_count_d;

    logic               mem0, br0, mem1, br1, raw, conflict, s0_mem;
    logic               one_v, one_mem;
    logic [PAYLOAD-1:0] one_p;

    assign mem0 = dec_class0 == CLS_MEM;
    assign br0  = dec_class0 == CLS_BR;
    assign mem1 = dec_class1 == CLS_MEM;
    assign br1  = dec_class1 == CLS_BR;
    assign raw  = dec_rf_we0 && dec_rd0 != '0 && (dec_rd0 == dec_rs1_1 || dec_rd0 == dec_rs2_1);
    assign conflict = dec_valid[0] && dec_valid[1] && ((mem0 && mem1) || (br0 && br1) || raw);
    // An ALU in slot 0 yields the branch pipe to a branch in slot 1.
    assign s0_mem = mem0 || (!br0 && br1);

    assign dec_stall   = !flush && (hold || state_q == SPLIT);
    assign br_valid    = br_valid_q;
    assign mem_valid   = mem_valid_q;
    assign br_payload  = br_payload_q;
    assign mem_payload = mem_payload_q;
    assign br_older    = br_older_q;
    assign split_count = split_count_q;

    always_comb begin
        state_d        = state_q;
        held_valid_d   = held_valid_q;
        held_class_d   = held_class_q;
        held_payload_d = held_payload_q;
        br_valid_d     = 1'b0;
        mem_valid_d    = 1'b0;
        br_payload_d   = br_payload_q;
        mem_payload_d  = mem_payload_q;
        br_older_d     = 1'b0;
        split_count_d  = split_count_q;
        one_v          = 1'b0;
        one_mem        = 1'b0;
        one_p          = dec_payload0;
        if (flush) begin
            state_d      = PAIR;
            held_valid_d = 1'b0;
        end else if (!hold) begin
            if (state_q == SPLIT) begin
                one_v        = held_valid_q;
                one_mem      = held_class_q == CLS_MEM;
                one_p        = held_payload_q;
                held_valid_d = 1'b0;
                state_d      = PAIR;
            end else if (conflict) begin
                one_v          = 1'b1;
                one_mem        = mem0;
                held_valid_d   = 1'b1;
                held_class_d   = dec_class1;
                held_payload_d = dec_payload1;
                state_d        = SPLIT;
                split_count_d  = &split_count_q ? split_count_q : split_count_q + 32'd1;
            end else if (&dec_valid) begin
                br_valid_d    = 1'b1;
                mem_valid_d   = 1'b1;
                br_payload_d  = s0_mem ? dec_payload1 : dec_payload0;
                mem_payload_d = s0_mem ? dec_payload0 : dec_payload1;
                br_older_d    = !s0_mem;
            end else begin
                one_v   = |dec_valid;
                one_mem = dec_valid[0] ? mem0 : mem1;
                one_p   = dec_valid[0] ? dec_payload0 : dec_payload1;
            end
        end
        if (one_v && one_mem) begin
            mem_valid_d   = 1'b1;
            mem_payload_d = one_p;
        end else if (one_v) begin
            br_valid_d   = 1'b1;
            br_payload_d = one_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= PAIR;
            held_valid_q   <= 1'b0;
            held_class_q   <= '0;
            held_payload_q <= '0;
            br_valid_q     <= 1'b0;
            mem_valid_q    <= 1'b0;
            br_payload_q   <= '0;
            mem_payload_q  <= '0;
            br_older_q     <= 1'b0;
            split_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            held_valid_q   <= held_valid_d;
            held_class_q   <= held_class_d;
            held_payload_q <= held_payload_d;
            br_valid_q     <= br_valid_d;
            mem_valid_q    <= mem_valid_d;
            br_payload_q   <= br_payload_d;
            mem_payload_q  <= mem_payload_d;
            br_older_q     <= br_older_d;
            split_count_q  <= split_count_d;
        end
    end
endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue-stage scheduler for the dual-issue core. Takes the two decoded instructions per cycle (slot 0 older), steers each to the Branch or Memory execution pipeline, and splits pairs that conflict structurally or carry an intra-pair RAW dependency. Outputs are the registered Issue→Execute pipeline registers for both pipes. It sits between the Decode/Issue stage and the two ALUs, and obeys hazard-unit hold and flush.

## Interface
- PAYLOAD, 96: opaque decoded-instruction bundle width (PC, imm, ALU op, rd, rs, control bits).
- RS, 5: register index width.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  2  bit i = slot i holds a valid instruction.
- dec_class0, dec_class1  in  2 each  00 ALU, 01 MEM (load/store), 10 BR (branch/JAL/JALR), 11 treated as ALU.
- dec_payload0, dec_payload1  in  PAYLOAD each  instruction bundles.
- dec_rd0  in  RS  slot 0 destination; dec_rf_we0  in  1  slot 0 writes RF.
- dec_rs1_1, dec_rs2_1  in  RS each  slot 1 sources.
- hold  in  1  hazard-unit stall (load-use).
- flush  in  1  branch/jump correction.
- dec_stall  out  1  Decode must keep its current pair.
- br_valid, mem_valid  out  1 each  pipe register valid.
- br_payload, mem_payload  out  PAYLOAD each  pipe register contents.
- br_older  out  1  branch-pipe instruction is older than memory-pipe instruction (valid only when both valid).
- split_count  out  32  saturating count of split pairs.

## Operation
- States: PAIR (normal), SPLIT (one held instruction pending). Held register: valid, class, payload.
- Classification: ALU may use either pipe; MEM only memory pipe; BR only branch pipe.
- Conflict = both slots valid and (both MEM, or both BR, or dec_rf_we0 && dec_rd0!=0 && (dec_rd0==dec_rs1_1 || dec_rd0==dec_rs2_1)).
- PAIR, no conflict, both valid: MEM→memory pipe, BR→branch pipe; ALU takes the remaining pipe; ALU+ALU: slot 0→branch, slot 1→memory. br_older=1 iff slot 0 went to branch pipe.
- PAIR, single valid slot: ALU or BR→branch pipe, MEM→memory pipe; other pipe invalid.
- PAIR, conflict: slot 0 issued per single-slot rule; slot 1 captured into held register; next state SPLIT; split_count+1 (saturates at 0xFFFF_FFFF); dec_stall stays 0 this cycle (pair consumed).
- SPLIT: dec_stall=1 (Moore, from state); held instruction issued per single-slot rule; held cleared; next state PAIR.
- hold=1 (no flush): both pipe registers load invalid (bubble); dec_stall=1; state, held register and split_count unchanged.
- flush=1: pipe registers invalid, held cleared, state PAIR, dec_stall=0; flush overrides hold and any capture in that cycle; split_count not incremented.
- Payloads of invalid pipe registers are don't-care but held stable on bubble to reduce toggling.

## Timing
- Reset (synchronous, rst=1 at a clk edge): state PAIR, held invalid, br_valid=0, mem_valid=0, br_older=0, split_count=0, payload registers 0; dec_stall=0 in the following cycle.
- Issue latency: pair presented in cycle N appears on br_*/mem_* after edge N+1 (one register).
- Split pair: slot 0 visible after edge N+1, slot 1 after edge N+2; dec_stall high during cycle N+1; next decode pair accepted at edge N+2.
- rst asserted mid-SPLIT discards the held instruction.
- flush in the same cycle as a conflicting pair: nothing issued, nothing held.
- hold during SPLIT: held instruction stays; issues in the first non-hold cycle.

## Test plan
- Reset: rst=1 one cycle → all valids 0, dec_stall 0, split_count 0.
- Pair MEM(slot0)+ALU(slot1), no RAW → after 1 edge mem_payload=payload0, br_payload=payload1, br_older=0, dec_stall never high.
- Pair BR+BR → edge 1: br_payload=payload0, mem_valid=0, dec_stall=1; edge 2: br_payload=payload1, dec_stall=0; split_count=1.
- RAW: slot0 ALU rd=5 we=1, slot1 ALU rs2=5 → split as above; same with rd=0 → paired, no split.
- Flush during SPLIT → next edge both valids 0, state PAIR, held instruction never issued, dec_stall=0.
- hold=1 for 2 cycles with pair ALU+ALU presented → two bubbles, dec_stall=1; on hold release pair issues with br_older=1.
